// File: rtl/uart_tx_engine.sv
// UART transmit engine: valid/ready byte intake into a one-entry holding
// register, framed serially (start, 8 data LSB-first, optional parity, stop bits).
module uart_tx_engine #(
  parameter int CLKS_PER_BIT = 5208,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic       clk,
  input  logic       txrst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       Tx,
  output logic       tx_busy,
  output logic       tx_done
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [2:0]    STOP_LAST = 3'(STOP_BITS - 1);
  localparam logic          ODD_BIT   = (PARITY_ODD != 0);
  localparam logic          PAR_ON    = (PARITY_EN != 0);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t        state, next_state;
  logic [CW-1:0] baud_cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shift;
  logic [7:0]    hold_data;
  logic          hold_full;
  logic          parity_bit;
  logic          load;
  logic          line_next;
  logic          busy_next;
  logic          done_next;
  logic          baud_last;
  logic          accept;

  assign tx_ready  = ~hold_full;
  assign accept    = tx_valid & tx_ready;
  assign baud_last = (baud_cnt == BAUD_LAST);

  always_ff @(posedge clk or posedge txrst) begin
    if (txrst) state <= IDLE;
    else       state <= next_state;
  end

  // Line/busy/done values are computed from the current state and registered,
  // so the visible frame trails the FSM by one cycle.
  always_comb begin
    next_state = state;
    load       = 1'b0;
    line_next  = 1'b1;
    busy_next  = 1'b1;
    done_next  = 1'b0;
    unique case (state)
      IDLE: begin
        busy_next = 1'b0;
        if (hold_full) begin
          load       = 1'b1;
          next_state = START;
        end
      end
      START: begin
        line_next = 1'b0;
        if (baud_last) next_state = DATA;
      end
      DATA: begin
        line_next = shift[0];
        if (baud_last && bit_idx == 3'd7) next_state = PAR_ON ? PARITY : STOP;
      end
      PARITY: begin
        line_next = parity_bit;
        if (baud_last) next_state = STOP;
      end
      STOP: begin
        if (baud_last && bit_idx == STOP_LAST) begin
          done_next = 1'b1;
          if (hold_full) begin
            load       = 1'b1;
            next_state = START;
          end else begin
            next_state = IDLE;
          end
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Baud and bit counters restart on every state change and rest in IDLE.
  always_ff @(posedge clk or posedge txrst) begin
    if (txrst) begin
      baud_cnt <= '0;
      bit_idx  <= '0;
    end else if (next_state != state || state == IDLE) begin
      baud_cnt <= '0;
      bit_idx  <= '0;
    end else if (baud_last) begin
      baud_cnt <= '0;
      bit_idx  <= bit_idx + 3'd1;
    end else begin
      baud_cnt <= baud_cnt + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge txrst) begin
    if (txrst) begin
      hold_data  <= '0;
      hold_full  <= 1'b0;
      shift      <= '0;
      parity_bit <= 1'b0;
    end else begin
      if (accept) begin
        hold_data <= tx_data;
        hold_full <= 1'b1;
      end else if (load) begin
        hold_full <= 1'b0;
      end
      if (load) begin
        shift      <= hold_data;
        parity_bit <= (^hold_data) ^ ODD_BIT;
      end else if (state == DATA && baud_last) begin
        shift <= shift >> 1;
      end
    end
  end

  always_ff @(posedge clk or posedge txrst) begin
    if (txrst) begin
      Tx      <= 1'b1;
      tx_busy <= 1'b0;
      tx_done <= 1'b0;
    end else begin
      Tx      <= line_next;
      tx_busy <= busy_next;
      tx_done <= done_next;
    end
  end

endmodule

// File: tb/tb_uart_tx_engine.sv
// Directed bench for uart_tx_engine: four instances (plain, even parity,
// odd parity, two stop bits) at 4 clocks per bit, checked cycle by cycle.
module tb_uart_tx_engine;

  localparam int CPB = 4;

  logic       clk;
  logic       rst;
  logic [7:0] tx_data;
  logic [3:0] valid;
  logic [3:0] ready;
  logic [3:0] line;
  logic [3:0] busy;
  logic [3:0] done;

  int n_assert;
  int n_fail;

  typedef struct packed {
    logic val;
    logic last;
  } ebit_t;

  ebit_t exp_q[$];

  uart_tx_engine #(.CLKS_PER_BIT(CPB)) dut0 (
    .clk(clk), .txrst(rst), .tx_data(tx_data), .tx_valid(valid[0]),
    .tx_ready(ready[0]), .Tx(line[0]), .tx_busy(busy[0]), .tx_done(done[0]));

  uart_tx_engine #(.CLKS_PER_BIT(CPB), .PARITY_EN(1)) dut1 (
    .clk(clk), .txrst(rst), .tx_data(tx_data), .tx_valid(valid[1]),
    .tx_ready(ready[1]), .Tx(line[1]), .tx_busy(busy[1]), .tx_done(done[1]));

  uart_tx_engine #(.CLKS_PER_BIT(CPB), .PARITY_EN(1), .PARITY_ODD(1)) dut2 (
    .clk(clk), .txrst(rst), .tx_data(tx_data), .tx_valid(valid[2]),
    .tx_ready(ready[2]), .Tx(line[2]), .tx_busy(busy[2]), .tx_done(done[2]));

  uart_tx_engine #(.CLKS_PER_BIT(CPB), .STOP_BITS(2)) dut3 (
    .clk(clk), .txrst(rst), .tx_data(tx_data), .tx_valid(valid[3]),
    .tx_ready(ready[3]), .Tx(line[3]), .tx_busy(busy[3]), .tx_done(done[3]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected line per bit period; 'last' marks the bit whose final cycle carries tx_done.
  function automatic void push_frame(input logic [7:0] b, input bit par_en,
                                     input bit par_odd, input int stops);
    exp_q.push_back(ebit_t'{val: 1'b0, last: 1'b0});
    for (int i = 0; i < 8; i++) exp_q.push_back(ebit_t'{val: b[i], last: 1'b0});
    if (par_en) exp_q.push_back(ebit_t'{val: (^b) ^ par_odd, last: 1'b0});
    for (int s = 1; s <= stops; s++) exp_q.push_back(ebit_t'{val: 1'b1, last: (s == stops)});
  endfunction

  // Called on the negedge of the first start-bit cycle.
  task automatic check_stream(input int idx, input string tag);
    ebit_t e;
    bit    first;
    first = 1'b1;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      for (int c = 0; c < CPB; c++) begin
        if (!first) @(negedge clk);
        first = 1'b0;
        check_output({tag, "_tx"},   32'(line[idx]), 32'(e.val));
        check_output({tag, "_busy"}, 32'(busy[idx]), 32'd1);
        check_output({tag, "_done"}, 32'(done[idx]), 32'(e.last && c == CPB - 1));
      end
    end
  endtask

  task automatic check_idle(input int idx, input string tag);
    check_output({tag, "_idle_tx"},   32'(line[idx]), 32'd1);
    check_output({tag, "_idle_busy"}, 32'(busy[idx]), 32'd0);
    check_output({tag, "_idle_done"}, 32'(done[idx]), 32'd0);
  endtask

  task automatic apply_stimulus(input int idx, input logic [7:0] b, input bit par_en,
                                input bit par_odd, input int stops, input string tag);
    @(negedge clk);
    tx_data    = b;
    valid[idx] = 1'b1;
    @(negedge clk);
    valid[idx] = 1'b0;
    tx_data    = ~b;
    check_output({tag, "_ready_low"}, 32'(ready[idx]), 32'd0);
    check_output({tag, "_tx_acc1"},   32'(line[idx]),  32'd1);
    @(negedge clk);
    check_output({tag, "_ready_back"}, 32'(ready[idx]), 32'd1);
    check_output({tag, "_tx_acc2"},    32'(line[idx]),  32'd1);
    check_output({tag, "_busy_acc2"},  32'(busy[idx]),  32'd0);
    push_frame(b, par_en, par_odd, stops);
    @(negedge clk);
    check_stream(idx, tag);
    @(negedge clk);
    check_idle(idx, tag);
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    rst      = 1'b1;
    valid    = '0;
    tx_data  = '0;

    #12;
    for (int i = 0; i < 4; i++) begin
      check_output("rst_tx",    32'(line[i]),  32'd1);
      check_output("rst_ready", 32'(ready[i]), 32'd1);
      check_output("rst_busy",  32'(busy[i]),  32'd0);
      check_output("rst_done",  32'(done[i]),  32'd0);
    end
    @(negedge clk);
    rst = 1'b0;

    apply_stimulus(0, 8'h55, 1'b0, 1'b0, 1, "t2_55");
    apply_stimulus(1, 8'h07, 1'b1, 1'b0, 1, "t4_even");
    apply_stimulus(2, 8'h07, 1'b1, 1'b1, 1, "t4_odd");
    apply_stimulus(3, 8'h81, 1'b0, 1'b0, 2, "t5_stop2");

    // Back-to-back: tx_valid stays high, second byte queues while first shifts.
    @(negedge clk);
    tx_data  = 8'h00;
    valid[0] = 1'b1;
    @(negedge clk);
    tx_data = 8'hFF;
    check_output("t3_ready_full", 32'(ready[0]), 32'd0);
    @(negedge clk);
    check_output("t3_ready_load", 32'(ready[0]), 32'd1);
    check_output("t3_tx_pre",     32'(line[0]),  32'd1);
    @(negedge clk);
    valid[0] = 1'b0;
    check_output("t3_second_acc", 32'(ready[0]), 32'd0);
    push_frame(8'h00, 1'b0, 1'b0, 1);
    push_frame(8'hFF, 1'b0, 1'b0, 1);
    check_stream(0, "t3_b2b");
    @(negedge clk);
    check_idle(0, "t3");

    // Reset in the middle of data bit 1 of 0xA5 (a low bit), then a clean frame.
    @(negedge clk);
    tx_data  = 8'hA5;
    valid[0] = 1'b1;
    @(negedge clk);
    valid[0] = 1'b0;
    @(negedge clk);
    repeat (10) @(negedge clk);
    check_output("t1_pre_rst_tx", 32'(line[0]), 32'd0);
    #1 rst = 1'b1;
    #1;
    check_output("t1_rst_tx",    32'(line[0]),  32'd1);
    check_output("t1_rst_ready", 32'(ready[0]), 32'd1);
    check_output("t1_rst_busy",  32'(busy[0]),  32'd0);
    check_output("t1_rst_done",  32'(done[0]),  32'd0);
    @(negedge clk);
    check_output("t1_rst_hold_tx", 32'(line[0]), 32'd1);
    rst = 1'b0;
    @(negedge clk);
    check_idle(0, "t1_after_rst");
    apply_stimulus(0, 8'h3C, 1'b0, 1'b0, 1, "t1_3c");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
